pwm_tone_decoder: RTL

Receive-side counterpart of the speaker PWM tone generator. It samples a single-bit PWM tone line and measures the period and high time of each PWM cycle. Each measurement is classified against the team's four tone classes, and a debounced tone class is reported together with a silence flag. Used for loop-back self-test of the audio path and for monitoring tone activity on the speaker net.

---
 rtl/audio_tone_pkg.sv | 31 +++
 rtl/pwm_edge_sync.sv | 23 ++
 rtl/pwm_tone_decoder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/audio_tone_pkg.sv
// Shared tone definitions for the speaker PWM generator and its loop-back decoder:
// class encoding, nominal PWM periods (generator counts 0..period) and tolerance helper.
package audio_tone_pkg;

  typedef enum logic [2:0] {
    TONE_NONE    = 3'd0,
    TONE_LOW     = 3'd1,
    TONE_MID     = 3'd2,
    TONE_HIGH    = 3'd3,
    TONE_HIGHER  = 3'd4,
    TONE_UNKNOWN = 3'd5
  } tone_class_e;

  typedef enum logic [1:0] {
    DEC_IDLE = 2'd0,
    DEC_ARM  = 2'd1,
    DEC_MEAS = 2'd2
  } dec_state_e;

  localparam int unsigned NOM_LOW    = 100001;
  localparam int unsigned NOM_MID    = 50001;
  localparam int unsigned NOM_HIGH   = 25001;
  localparam int unsigned NOM_HIGHER = 12501;

  localparam int unsigned DEFAULT_TOL_SHIFT = 4;

  function automatic int unsigned tone_tol(input int unsigned nominal, input int unsigned shift);
    return nominal >> shift;
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Brings the asynchronous PWM line into the clk domain and flags its rising/falling edges.
module pwm_edge_sync (
  input  logic clk,
  input  logic pwm_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  // Left unreset so a line that is high through reset does not fake a rising edge.
  always_ff @(posedge clk) begin
    meta_q <= pwm_i;
    sync_q <= meta_q;
    dly_q  <= sync_q;
  end

  assign rise_o = sync_q & ~dly_q;
  assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/pwm_tone_decoder.sv
// Measures period and high time of each PWM cycle on the tone line, classifies it
// against the four tone classes and reports a debounced class plus a silence flag.
module pwm_tone_decoder #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned TIMEOUT   = 200000,
  parameter int unsigned TOL_SHIFT = 4,
  parameter int unsigned STABLE_N  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic [2:0]       meas_class,
  output logic             duty_ok,
  output logic [2:0]       tone_class,
  output logic             tone_stable,
  output logic             silent
);

  import audio_tone_pkg::*;

  localparam int unsigned RUN_W = $clog2(STABLE_N + 1);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  localparam logic [CNT_W-1:0] NOM_LOW_C    = CNT_W'(NOM_LOW);
  localparam logic [CNT_W-1:0] NOM_MID_C    = CNT_W'(NOM_MID);
  localparam logic [CNT_W-1:0] NOM_HIGH_C   = CNT_W'(NOM_HIGH);
  localparam logic [CNT_W-1:0] NOM_HIGHER_C = CNT_W'(NOM_HIGHER);

  localparam logic [CNT_W-1:0] TOL_LOW_C    = CNT_W'(tone_tol(NOM_LOW, TOL_SHIFT));
  localparam logic [CNT_W-1:0] TOL_MID_C    = CNT_W'(tone_tol(NOM_MID, TOL_SHIFT));
  localparam logic [CNT_W-1:0] TOL_HIGH_C   = CNT_W'(tone_tol(NOM_HIGH, TOL_SHIFT));
  localparam logic [CNT_W-1:0] TOL_HIGHER_C = CNT_W'(tone_tol(NOM_HIGHER, TOL_SHIFT));

  localparam logic [CNT_W-1:0] HALF_LOW_C    = CNT_W'(NOM_LOW >> 1);
  localparam logic [CNT_W-1:0] HALF_MID_C    = CNT_W'(NOM_MID >> 1);
  localparam logic [CNT_W-1:0] HALF_HIGH_C   = CNT_W'(NOM_HIGH >> 1);
  localparam logic [CNT_W-1:0] HALF_HIGHER_C = CNT_W'(NOM_HIGHER >> 1);

  function automatic logic within_tol(input logic [CNT_W-1:0] val,
                                      input logic [CNT_W-1:0] target,
                                      input logic [CNT_W-1:0] tol);
    logic signed [CNT_W:0] diff;
    diff = $signed({1'b0, val}) - $signed({1'b0, target});
    if (diff < 0) diff = -diff;
    return diff <= $signed({1'b0, tol});
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TIMEOUT_C) ? TIMEOUT_C : v + CNT_W'(1);
  endfunction

  logic rise;
  logic fall;

  pwm_edge_sync u_edge_sync (
    .clk    (clk),
    .pwm_i  (pwm_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  dec_state_e       state_q;
  logic [CNT_W-1:0] per_cnt_q;
  logic [CNT_W-1:0] hi_cnt_q;
  logic             hi_run_q;
  logic             meas_valid_q;
  logic [CNT_W-1:0] meas_period_q;
  logic [CNT_W-1:0] meas_high_q;
  logic [2:0]       meas_class_q;
  logic             duty_ok_q;
  logic             silent_q;

  logic [2:0]       tone_class_q;
  logic             tone_stable_q;
  logic [2:0]       cand_q;
  logic [RUN_W-1:0] run_q;

  logic [2:0]       cls_d;
  logic             duty_d;
  logic [CNT_W-1:0] half_d;
  logic [CNT_W-1:0] tol_d;
  logic             timeout_hit;

  // First matching class wins; duty is judged against that class's nominal half period.
  always_comb begin
    cls_d  = TONE_UNKNOWN;
    half_d = '0;
    tol_d  = '0;
    if (within_tol(per_cnt_q, NOM_LOW_C, TOL_LOW_C)) begin
      cls_d = TONE_LOW;    half_d = HALF_LOW_C;    tol_d = TOL_LOW_C;
    end else if (within_tol(per_cnt_q, NOM_MID_C, TOL_MID_C)) begin
      cls_d = TONE_MID;    half_d = HALF_MID_C;    tol_d = TOL_MID_C;
    end else if (within_tol(per_cnt_q, NOM_HIGH_C, TOL_HIGH_C)) begin
      cls_d = TONE_HIGH;   half_d = HALF_HIGH_C;   tol_d = TOL_HIGH_C;
    end else if (within_tol(per_cnt_q, NOM_HIGHER_C, TOL_HIGHER_C)) begin
      cls_d = TONE_HIGHER; half_d = HALF_HIGHER_C; tol_d = TOL_HIGHER_C;
    end
    duty_d = (cls_d != TONE_UNKNOWN) && within_tol(hi_cnt_q, half_d, tol_d);
  end

  // A rise in the same cycle as the timeout keeps the line alive.
  assign timeout_hit = (state_q != DEC_IDLE) && !rise && (per_cnt_q == TIMEOUT_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= DEC_IDLE;
      per_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      hi_run_q      <= 1'b0;
      meas_valid_q  <= 1'b0;
      meas_period_q <= '0;
      meas_high_q   <= '0;
      meas_class_q  <= TONE_NONE;
      duty_ok_q     <= 1'b0;
      silent_q      <= 1'b1;
    end else begin
      meas_valid_q <= 1'b0;
      case (state_q)
        DEC_IDLE: begin
          if (rise) begin
            state_q   <= DEC_ARM;
            per_cnt_q <= CNT_W'(1);
            hi_cnt_q  <= CNT_W'(1);
            hi_run_q  <= 1'b1;
            silent_q  <= 1'b0;
          end
        end
        DEC_ARM, DEC_MEAS: begin
          if (rise) begin
            state_q       <= DEC_MEAS;
            meas_valid_q  <= 1'b1;
            meas_period_q <= per_cnt_q;
            meas_high_q   <= hi_cnt_q;
            meas_class_q  <= cls_d;
            duty_ok_q     <= duty_d;
            per_cnt_q     <= CNT_W'(1);
            hi_cnt_q      <= CNT_W'(1);
            hi_run_q      <= 1'b1;
          end else if (timeout_hit) begin
            state_q  <= DEC_IDLE;
            silent_q <= 1'b1;
          end else begin
            per_cnt_q <= sat_inc(per_cnt_q);
            if (fall) begin
              hi_run_q <= 1'b0;
            end else if (hi_run_q) begin
              hi_cnt_q <= sat_inc(hi_cnt_q);
            end
          end
        end
        default: state_q <= DEC_IDLE;
      endcase
    end
  end

  // Debounce runs one cycle behind the registered measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      tone_class_q  <= TONE_NONE;
      tone_stable_q <= 1'b0;
      cand_q        <= TONE_NONE;
      run_q         <= '0;
    end else if (timeout_hit) begin
      tone_class_q  <= TONE_NONE;
      tone_stable_q <= 1'b0;
      cand_q        <= TONE_NONE;
      run_q         <= '0;
    end else if (meas_valid_q) begin
      if (duty_ok_q && (meas_class_q >= TONE_LOW) && (meas_class_q <= TONE_HIGHER)) begin
        if (meas_class_q == cand_q) begin
          if (run_q >= RUN_W'(STABLE_N - 1)) begin
            run_q         <= RUN_W'(STABLE_N);
            tone_class_q  <= cand_q;
            tone_stable_q <= 1'b1;
          end else begin
            run_q <= run_q + RUN_W'(1);
          end
        end else begin
          cand_q        <= meas_class_q;
          run_q         <= RUN_W'(1);
          tone_stable_q <= 1'b0;
        end
      end else begin
        cand_q        <= TONE_NONE;
        run_q         <= '0;
        tone_stable_q <= 1'b0;
      end
    end
  end

  assign meas_valid  = meas_valid_q;
  assign meas_period = meas_period_q;
  assign meas_high   = meas_high_q;
  assign meas_class  = meas_class_q;
  assign duty_ok     = duty_ok_q;
  assign tone_class  = tone_class_q;
  assign tone_stable = tone_stable_q;
  assign silent      = silent_q;

endmodule
